// File: rtl/traffic_ctrl_n.sv
// ---------------------------------------------------------------------------
// traffic_ctrl_n : multi-approach round-robin traffic-light controller
//
// Serves N_DIR approaches in turn. Every phase is timed in units of the
// external one-cycle `tick` enable. Features:
//   - demand-driven direction selection: skips approaches without requests
//   - green extension while only the current approach has demand, capped
//     at GREEN_MAX
//   - night flashing-yellow mode, entered and left through an all-red
//     clearance phase
//
// Ports
//   clk        : clock, all state changes on rising edge
//   rst_n      : asynchronous active-low reset -> ALLRED, cur_dir = N_DIR-1
//   tick       : timing enable; the timer and state only move when tick=1
//   veh_req    : per-approach vehicle-present level
//   flash_mode : level request for flashing mode
//   lights     : {red,yellow,green} per approach, approach d at [3d+2:3d]
//   cur_dir    : approach currently owning (or last owning) green
//   flashing   : high while in FLASH
// ---------------------------------------------------------------------------

// Per-approach lamp decoder. It is driven only from registered state, so
// no input has a combinational path to the lamps.
module traffic_lamp (
    input  logic       sel,     // this approach owns cur_dir
    input  logic       grn,     // controller is in GREEN
    input  logic       yel,     // controller is in YELLOW
    input  logic       fl,      // controller is in FLASH
    input  logic       blink,   // flash phase: 1 = lit
    output logic [2:0] lamp     // {red, yellow, green}
);
    always_comb begin
        lamp = 3'b100;
        if (fl)
            lamp = blink ? 3'b010 : 3'b000;
        else if (grn && sel)
            lamp = 3'b001;
        else if (yel && sel)
            lamp = 3'b010;
    end
endmodule

module traffic_ctrl_n #(
    parameter int N_DIR     = 2,
    parameter int CNT_W     = 4,
    parameter int GREEN_T   = 5,
    parameter int YELLOW_T  = 1,
    parameter int ALLRED_T  = 1,
    parameter int GREEN_MAX = 10
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           tick,
    input  logic [N_DIR-1:0]                               veh_req,
    input  logic                                           flash_mode,
    output logic [3*N_DIR-1:0]                             lights,
    output logic [((N_DIR > 1) ? $clog2(N_DIR) : 1)-1:0]   cur_dir,
    output logic                                           flashing
);
    localparam int DW = (N_DIR > 1) ? $clog2(N_DIR) : 1;
    localparam logic [DW-1:0] LAST = DW'(N_DIR - 1);

    // Durations widened by one bit so t+1 never wraps at the compare.
    localparam logic [CNT_W:0] GT = (CNT_W+1)'(GREEN_T);
    localparam logic [CNT_W:0] YT = (CNT_W+1)'(YELLOW_T);
    localparam logic [CNT_W:0] AT = (CNT_W+1)'(ALLRED_T);
    localparam logic [CNT_W:0] GM = (CNT_W+1)'(GREEN_MAX);

    localparam logic [1:0] S_ALLRED = 2'd0;
    localparam logic [1:0] S_GREEN  = 2'd1;
    localparam logic [1:0] S_YELLOW = 2'd2;
    localparam logic [1:0] S_FLASH  = 2'd3;

    logic [1:0]       state;
    logic [CNT_W-1:0] t;
    logic             blink;
    logic [CNT_W:0]   t1;
    logic [N_DIR-1:0] dir_oh;
    logic             extend;
    logic [DW-1:0]    nxt_dir;
    logic [DW-1:0]    cand;
    logic             found;

    assign t1 = {1'b0, t} + 1'b1;

    always_comb begin
        dir_oh          = '0;
        dir_oh[cur_dir] = 1'b1;
    end

    // Extend green only for an uncontested, still-requesting approach.
    assign extend = veh_req[cur_dir] && ((veh_req & ~dir_oh) == '0) &&
                    !flash_mode && (t1 < GM);

    // Round-robin search starting after cur_dir; cur_dir itself is the last
    // candidate. With no demand at all, simply advance by one.
    always_comb begin
        nxt_dir = (cur_dir == LAST) ? '0 : cur_dir + 1'b1;
        found   = 1'b0;
        cand    = cur_dir;
        for (int k = 0; k < N_DIR; k++) begin
            cand = (cand == LAST) ? '0 : cand + 1'b1;
            if (!found && veh_req[cand]) begin
                found   = 1'b1;
                nxt_dir = cand;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= S_ALLRED;
            t       <= '0;
            cur_dir <= LAST;
            blink   <= 1'b0;
        end else begin
            case (state)
                S_ALLRED: if (tick) begin
                    if (t1 == AT) begin
                        t <= '0;
                        if (flash_mode) begin
                            state <= S_FLASH;
                            blink <= 1'b1;
                        end else begin
                            state   <= S_GREEN;
                            cur_dir <= nxt_dir;
                        end
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                S_GREEN: if (tick) begin
                    // Minimum green always runs out before flash or
                    // competing demand is considered.
                    if (t1 >= GT && !extend) begin
                        state <= S_YELLOW;
                        t     <= '0;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                S_YELLOW: if (tick) begin
                    if (t1 == YT) begin
                        state <= S_ALLRED;
                        t     <= '0;
                    end else begin
                        t <= t + 1'b1;
                    end
                end
                S_FLASH: if (tick) begin
                    blink <= ~blink;
                    if (!flash_mode) begin
                        state <= S_ALLRED;
                        t     <= '0;
                    end
                end
                default: begin
                    state <= S_ALLRED;
                    t     <= '0;
                end
            endcase
        end
    end

    assign flashing = (state == S_FLASH);

    for (genvar d = 0; d < N_DIR; d++) begin : g_lamp
        traffic_lamp u_lamp (
            .sel   (cur_dir == DW'(d)),
            .grn   (state == S_GREEN),
            .yel   (state == S_YELLOW),
            .fl    (state == S_FLASH),
            .blink (blink),
            .lamp  (lights[3*d +: 3])
        );
    end

endmodule
